// File: rtl/cpu_registers.sv
// cpu_registers
// -------------
// Architectural register file of the 6502 core: A, X, Y, SP, PC and P.
// Values are latched on the rising clock edge under per-register enables and
// driven continuously to the rest of the core.
//
// Optional feature macro: CPU_REGS_STACK_OPS_EN
//   defined     -> sp_inc / sp_dec step the stack pointer (pull / push)
//   not defined -> sp_inc / sp_dec are ignored; SP changes only by sp_write
//                  or reset
//
// Ports:
//   clk                    single clock, rising edge
//   rst                    synchronous active-high reset
//   a_write/x_write/y_write  load data_in into A / X / Y
//   sp_write               load data_in into SP
//   p_write                load data_in into P (raw, all 8 bits)
//   pc_write               load addr_in into PC
//   pc_inc                 PC <= PC + 1 (lower priority than pc_write)
//   sp_inc / sp_dec        SP step up / down (lower priority than sp_write)
//   nz_update              P[7] <= data_in[7], P[1] <= (data_in == 0)
//   data_in [7:0]          write data for the 8-bit registers
//   addr_in [15:0]         write data for PC
//   reg_a/x/y/sp/p [7:0]   current register values
//   reg_pc [15:0]          current PC
//   stack_addr [15:0]      {8'h01, reg_sp}, combinational
module cpu_registers #(
  parameter logic [15:0] RESET_PC = 16'h0200,
  parameter logic [7:0]  RESET_SP = 8'hFF,
  parameter logic [7:0]  RESET_P  = 8'h20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_write,
  input  logic        x_write,
  input  logic        y_write,
  input  logic        sp_write,
  input  logic        p_write,
  input  logic        pc_write,
  input  logic        pc_inc,
  input  logic        sp_inc,
  input  logic        sp_dec,
  input  logic        nz_update,
  input  logic [7:0]  data_in,
  input  logic [15:0] addr_in,
  output logic [7:0]  reg_a,
  output logic [7:0]  reg_x,
  output logic [7:0]  reg_y,
  output logic [7:0]  reg_sp,
  output logic [7:0]  reg_p,
  output logic [15:0] reg_pc,
  output logic [15:0] stack_addr
);

  // Effective stack step requests. Asserting both inc and dec cancels out,
  // so each is qualified by the absence of the other.
  logic sp_step_up;
  logic sp_step_down;

`ifdef CPU_REGS_STACK_OPS_EN
  assign sp_step_up   = sp_inc & ~sp_dec;
  assign sp_step_down = sp_dec & ~sp_inc;
`else
  // Stack stepping disabled: the ports stay but are deliberately ignored.
  logic unused_stack_ops;
  assign unused_stack_ops = sp_inc ^ sp_dec;
  assign sp_step_up       = 1'b0;
  assign sp_step_down     = 1'b0;
`endif

  // Data registers: plain load enables, all sharing data_in.
  always_ff @(posedge clk) begin
    if (rst) begin
      reg_a <= 8'h00;
      reg_x <= 8'h00;
      reg_y <= 8'h00;
    end else begin
      if (a_write) reg_a <= data_in;
      if (x_write) reg_x <= data_in;
      if (y_write) reg_y <= data_in;
    end
  end

  // Program counter: an explicit load beats an increment; the increment
  // wraps naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      reg_pc <= RESET_PC;
    end else if (pc_write) begin
      reg_pc <= addr_in;
    end else if (pc_inc) begin
      reg_pc <= reg_pc + 16'd1;
    end
  end

  // Stack pointer: load beats stepping; stepping wraps within page 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      reg_sp <= RESET_SP;
    end else if (sp_write) begin
      reg_sp <= data_in;
    end else if (sp_step_up) begin
      reg_sp <= reg_sp + 8'd1;
    end else if (sp_step_down) begin
      reg_sp <= reg_sp - 8'd1;
    end
  end

  // Status register is stored raw (bit 5 is not forced). An N/Z update only
  // touches bits 7 and 1 and loses to a full load.
  always_ff @(posedge clk) begin
    if (rst) begin
      reg_p <= RESET_P;
    end else if (p_write) begin
      reg_p <= data_in;
    end else if (nz_update) begin
      reg_p[7] <= data_in[7];
      reg_p[1] <= (data_in == 8'h00);
    end
  end

  // The 6502 stack lives in page 1.
  assign stack_addr = {8'h01, reg_sp};

endmodule

// File: tb/tb_cpu_registers.sv
// tb_cpu_registers
// ----------------
// Self-checking bench for cpu_registers: directed steps followed by random
// traffic, compared against a behavioural model of the register rules.
module tb_cpu_registers;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_write, x_write, y_write, sp_write, p_write;
  logic        pc_write, pc_inc, sp_inc, sp_dec, nz_update;
  logic [7:0]  data_in;
  logic [15:0] addr_in;
  logic [7:0]  reg_a, reg_x, reg_y, reg_sp, reg_p;
  logic [15:0] reg_pc, stack_addr;

  int checks = 0;
  int errors = 0;

  // Model state, kept as plain integers.
  int ma, mx, my, msp, mp, mpc;

`ifdef CPU_REGS_STACK_OPS_EN
  localparam bit STACK_EN = 1'b1;
`else
  localparam bit STACK_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  cpu_registers dut (
    .clk        (clk),
    .rst        (rst),
    .a_write    (a_write),
    .x_write    (x_write),
    .y_write    (y_write),
    .sp_write   (sp_write),
    .p_write    (p_write),
    .pc_write   (pc_write),
    .pc_inc     (pc_inc),
    .sp_inc     (sp_inc),
    .sp_dec     (sp_dec),
    .nz_update  (nz_update),
    .data_in    (data_in),
    .addr_in    (addr_in),
    .reg_a      (reg_a),
    .reg_x      (reg_x),
    .reg_y      (reg_y),
    .reg_sp     (reg_sp),
    .reg_p      (reg_p),
    .reg_pc     (reg_pc),
    .stack_addr (stack_addr)
  );

  task automatic clear_inputs();
    rst = 1'b0;
    a_write = 1'b0; x_write = 1'b0; y_write = 1'b0;
    sp_write = 1'b0; p_write = 1'b0; pc_write = 1'b0;
    pc_inc = 1'b0; sp_inc = 1'b0; sp_dec = 1'b0; nz_update = 1'b0;
  endtask

  task automatic check_one(input string tag, input logic [15:0] got,
                           input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_output(input string step);
    check_one({step, ".reg_a"},      {8'h00, reg_a},  16'(ma));
    check_one({step, ".reg_x"},      {8'h00, reg_x},  16'(mx));
    check_one({step, ".reg_y"},      {8'h00, reg_y},  16'(my));
    check_one({step, ".reg_sp"},     {8'h00, reg_sp}, 16'(msp));
    check_one({step, ".reg_p"},      {8'h00, reg_p},  16'(mp));
    check_one({step, ".reg_pc"},     reg_pc,          16'(mpc));
    check_one({step, ".stack_addr"}, stack_addr,      16'(256 + msp));
  endtask

  // Applies the currently driven inputs for one rising edge, advances the
  // model by the register rules, then checks every output and clears the
  // enables.
  task automatic apply_stimulus(input string step);
    int d;
    d = int'(data_in);
    @(posedge clk);
    if (rst) begin
      ma = 0; mx = 0; my = 0; msp = 'hFF; mpc = 'h0200; mp = 'h20;
    end else begin
      if (a_write) ma = d;
      if (x_write) mx = d;
      if (y_write) my = d;
      if (pc_write)     mpc = int'(addr_in);
      else if (pc_inc)  mpc = (mpc + 1) % 65536;
      if (sp_write) msp = d;
      else if (STACK_EN && sp_inc && !sp_dec) msp = (msp + 1) % 256;
      else if (STACK_EN && sp_dec && !sp_inc) msp = (msp + 255) % 256;
      if (p_write) mp = d;
      else if (nz_update)
        mp = (mp % 256) - (mp & 'h82) + (d & 'h80) + ((d == 0) ? 2 : 0);
    end
    #1;
    check_output(step);
    clear_inputs();
  endtask

  initial begin
    ma = 0; mx = 0; my = 0; msp = 0; mp = 0; mpc = 0;
    clear_inputs();
    data_in = 8'h00;
    addr_in = 16'h0000;

    // Reset held for two edges
    rst = 1'b1; apply_stimulus("reset0");
    rst = 1'b1; apply_stimulus("reset1");
    check_one("reset_pc_literal", reg_pc, 16'h0200);
    check_one("reset_p_literal", {8'h00, reg_p}, 16'h0020);

    // Single writes
    data_in = 8'h55; a_write = 1'b1;  apply_stimulus("write_a");
    data_in = 8'hAA; x_write = 1'b1;  apply_stimulus("write_x");
    data_in = 8'h33; y_write = 1'b1;  apply_stimulus("write_y");
    data_in = 8'hF0; sp_write = 1'b1; apply_stimulus("write_sp");
    data_in = 8'hC3; p_write = 1'b1;  apply_stimulus("write_p");
    check_one("p_raw_c3", {8'h00, reg_p}, 16'h00C3);
    addr_in = 16'h1234; pc_write = 1'b1; apply_stimulus("write_pc");

    // All writes together
    data_in = 8'h77; addr_in = 16'h5678;
    a_write = 1'b1; x_write = 1'b1; y_write = 1'b1;
    sp_write = 1'b1; p_write = 1'b1; pc_write = 1'b1;
    apply_stimulus("write_all");

    // PC wrap and priority; held increment
    addr_in = 16'hFFFF; pc_write = 1'b1; apply_stimulus("pc_ffff");
    pc_inc = 1'b1; apply_stimulus("pc_wrap");
    check_one("pc_wrap_literal", reg_pc, 16'h0000);
    addr_in = 16'h4000; pc_write = 1'b1; pc_inc = 1'b1;
    apply_stimulus("pc_prio");
    for (int i = 0; i < 3; i++) begin
      pc_inc = 1'b1; apply_stimulus("pc_hold_inc");
    end
    check_one("pc_plus3", reg_pc, 16'h4003);

    // SP wrap and cancel
    data_in = 8'h00; sp_write = 1'b1; apply_stimulus("sp_00");
    sp_dec = 1'b1; apply_stimulus("sp_dec_wrap");
    sp_inc = 1'b1; sp_dec = 1'b1; apply_stimulus("sp_cancel");
    data_in = 8'hFF; sp_write = 1'b1; sp_inc = 1'b1;
    apply_stimulus("sp_prio");
    sp_inc = 1'b1; apply_stimulus("sp_inc_wrap");

    // Flags
    data_in = 8'h20; p_write = 1'b1; apply_stimulus("p_20");
    data_in = 8'h00; nz_update = 1'b1; apply_stimulus("nz_zero");
    check_one("nz_zero_literal", {8'h00, reg_p}, 16'h0022);
    data_in = 8'h80; nz_update = 1'b1; apply_stimulus("nz_neg");
    check_one("nz_neg_literal", {8'h00, reg_p}, 16'h00A0);
    data_in = 8'h00; p_write = 1'b1; nz_update = 1'b1;
    apply_stimulus("p_prio");

    // Reset wins over a write in the same edge
    data_in = 8'h99; a_write = 1'b1; apply_stimulus("pre_reset");
    rst = 1'b1; a_write = 1'b1; pc_inc = 1'b1; apply_stimulus("reset_mid");
    check_one("reset_mid_a", {8'h00, reg_a}, 16'h0000);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      rst       = ($urandom_range(0, 29) == 0);
      a_write   = 1'($urandom_range(0, 1));
      x_write   = 1'($urandom_range(0, 1));
      y_write   = 1'($urandom_range(0, 1));
      sp_write  = ($urandom_range(0, 3) == 0);
      p_write   = ($urandom_range(0, 3) == 0);
      pc_write  = ($urandom_range(0, 3) == 0);
      pc_inc    = 1'($urandom_range(0, 1));
      sp_inc    = 1'($urandom_range(0, 1));
      sp_dec    = 1'($urandom_range(0, 1));
      nz_update = 1'($urandom_range(0, 1));
      data_in   = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      addr_in   = 16'($urandom);
      apply_stimulus("random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
